ascon_fsm: RTL and testbench

ASCON_FSM -- requirements
Module: ascon_fsm

---
 rtl/ascon_fsm_if.sv | 30 +++
 rtl/ascon_fsm.sv | 176 +++++++++++++++++
 tb/tb_ascon_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_fsm_if.sv
// Handshake and control bundle between the ASCON-128 sequencer and its environment.
// The master drives start/data-valid; the slave (ascon_fsm) drives the permutation controls.
interface ascon_fsm_if;
  logic       start_i;
  logic [3:0] nb_blocks_i;
  logic       data_valid_i;
  logic       data_ack_o;
  logic       data_sel_o;
  logic       select_o;
  logic       enable_o;
  logic [3:0] round_o;
  logic [1:0] etat_up_o;
  logic [1:0] etat_down_o;
  logic       cipher_valid_o;
  logic       tag_valid_o;
  logic       busy_o;
  logic [3:0] block_idx_o;

  modport master (
    output start_i, nb_blocks_i, data_valid_i,
    input  data_ack_o, data_sel_o, select_o, enable_o, round_o, etat_up_o,
           etat_down_o, cipher_valid_o, tag_valid_o, busy_o, block_idx_o
  );

  modport slave (
    input  start_i, nb_blocks_i, data_valid_i,
    output data_ack_o, data_sel_o, select_o, enable_o, round_o, etat_up_o,
           etat_down_o, cipher_valid_o, tag_valid_o, busy_o, block_idx_o
  );
endinterface

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption sequencer: steps a permutation_xor datapath through
// initialisation, one AD block, N plaintext blocks and finalisation.
module ascon_fsm (
  input  logic        clock_i,
  input  logic        reset_i,
  ascon_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_END
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] n_q, n_d;
  logic [3:0] blk_s;
  logic       last_s;

  logic       data_ack_s, data_sel_s, select_s, enable_s;
  logic       cipher_valid_s, tag_valid_s, busy_s;
  logic [1:0] etat_up_s, etat_down_s;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      n_q     <= 4'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
    end
  end

  // Index of the block that follows the current phase; the last one goes through FINAL.
  always_comb begin
    if (state_q == S_PT) begin
      blk_s = idx_q + 4'd1;
    end else if (state_q == S_AD) begin
      blk_s = 4'd0;
    end else begin
      blk_s = idx_q;
    end
    last_s = (blk_s == (n_q - 4'd1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_INIT;
          cnt_d   = 4'd0;
          idx_d   = 4'd0;
          n_d     = (bus.nb_blocks_i == 4'd0) ? 4'd1 : bus.nb_blocks_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (cnt_q != 4'd11) begin
          cnt_d = cnt_q + 4'd1;
        end else if (bus.data_valid_i) begin
          state_d = S_AD;
          cnt_d   = 4'd6;
        end else begin
          state_d = S_WAIT_AD;
        end
      end
      S_WAIT_AD: begin
        if (bus.data_valid_i) begin
          state_d = S_AD;
          cnt_d   = 4'd6;
        end else begin
          state_d = S_WAIT_AD;
        end
      end
      S_AD, S_PT, S_WAIT_PT: begin
        if ((state_q != S_WAIT_PT) && (cnt_q != 4'd11)) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          idx_d = blk_s;
          if (bus.data_valid_i) begin
            state_d = last_s ? S_FINAL : S_PT;
            cnt_d   = last_s ? 4'd0 : 4'd6;
          end else begin
            state_d = S_WAIT_PT;
          end
        end
      end
      S_FINAL: begin
        if (cnt_q != 4'd11) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        idx_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Moore output decode from state and round counter.
  always_comb begin
    data_ack_s     = 1'b0;
    data_sel_s     = 1'b0;
    select_s       = 1'b0;
    enable_s       = 1'b0;
    etat_up_s      = 2'd0;
    etat_down_s    = 2'd0;
    cipher_valid_s = 1'b0;
    tag_valid_s    = 1'b0;
    busy_s         = (state_q != S_IDLE);
    case (state_q)
      S_INIT: begin
        enable_s    = 1'b1;
        select_s    = (cnt_q == 4'd0);
        etat_down_s = (cnt_q == 4'd11) ? 2'd2 : 2'd0;
      end
      S_AD: begin
        enable_s    = 1'b1;
        data_ack_s  = (cnt_q == 4'd6);
        etat_up_s   = (cnt_q == 4'd6) ? 2'd1 : 2'd0;
        etat_down_s = (cnt_q == 4'd11) ? 2'd1 : 2'd0;
      end
      S_PT: begin
        enable_s       = 1'b1;
        data_sel_s     = 1'b1;
        data_ack_s     = (cnt_q == 4'd6);
        cipher_valid_s = (cnt_q == 4'd6);
        etat_up_s      = (cnt_q == 4'd6) ? 2'd1 : 2'd0;
      end
      S_FINAL: begin
        enable_s       = 1'b1;
        data_sel_s     = 1'b1;
        data_ack_s     = (cnt_q == 4'd0);
        cipher_valid_s = (cnt_q == 4'd0);
        etat_up_s      = (cnt_q == 4'd0) ? 2'd3 : 2'd0;
        etat_down_s    = (cnt_q == 4'd11) ? 2'd2 : 2'd0;
      end
      S_END: begin
        tag_valid_s = 1'b1;
      end
      default: begin
        enable_s = 1'b0;
      end
    endcase
  end

  assign bus.data_ack_o     = data_ack_s;
  assign bus.data_sel_o     = data_sel_s;
  assign bus.select_o       = select_s;
  assign bus.enable_o       = enable_s;
  assign bus.round_o        = cnt_q;
  assign bus.etat_up_o      = etat_up_s;
  assign bus.etat_down_o    = etat_down_s;
  assign bus.cipher_valid_o = cipher_valid_s;
  assign bus.tag_valid_o    = tag_valid_s;
  assign bus.busy_o         = busy_s;
  assign bus.block_idx_o    = idx_q;

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: a phase-list reference model predicts every output each cycle.
// Latencies are counted inclusive of the cycle in which start_i is presented.
module tb_ascon_fsm;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ascon_fsm_if bus ();
  ascon_fsm dut (.clock_i(clk), .reset_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model: a run is a list of phases (INIT=1, AD=2, PT=3, FINAL=4, END=5).
  bit m_idle;
  bit m_wait;
  int m_ph, m_r, m_waits, m_np, m_n;
  int ph_kind[20], ph_first[20], ph_last[20], ph_idx[20];
  bit ph_gated[20];

  function automatic void add_phase(int kind, int first, int last, int idx, bit gated);
    ph_kind[m_np] = kind; ph_first[m_np] = first; ph_last[m_np] = last;
    ph_idx[m_np] = idx; ph_gated[m_np] = gated;
    m_np++;
  endfunction

  function automatic void model_start(logic [3:0] nb);
    m_n = (nb == 4'd0) ? 1 : int'(nb);
    m_np = 0;
    add_phase(1, 0, 11, 0, 1'b0);
    add_phase(2, 6, 11, 0, 1'b1);
    for (int k = 0; k < m_n - 1; k++) add_phase(3, 6, 11, k, 1'b1);
    add_phase(4, 0, 11, m_n - 1, 1'b1);
    add_phase(5, 0, 0, m_n - 1, 1'b0);
    m_idle = 1'b0; m_ph = 0; m_r = 0; m_wait = 1'b0; m_waits = 0;
  endfunction

  function automatic void model_advance(logic st, logic dv, logic [3:0] nb);
    if (m_idle) begin
      if (st) model_start(nb);
    end else if (m_wait) begin
      m_waits++;
      if (dv) m_wait = 1'b0;
    end else if (ph_kind[m_ph] == 5) begin
      m_idle = 1'b1;
    end else if (m_r == ph_last[m_ph]) begin
      m_ph++;
      m_r = ph_first[m_ph];
      m_wait = ph_gated[m_ph] && !dv;
    end else begin
      m_r++;
    end
  endfunction

  // Packing: ack dsel sel en round[4] up[2] down[2] cv tag busy idx[4]
  function automatic logic [18:0] model_out();
    logic ack, dsel, sel, en, cv, tag, busy;
    logic [3:0] rnd, idx;
    logic [1:0] up, dn;
    int k;
    ack = 0; dsel = 0; sel = 0; en = 0; cv = 0; tag = 0; busy = 0;
    rnd = 4'd0; idx = 4'd0; up = 2'd0; dn = 2'd0;
    if (!m_idle) begin
      busy = 1'b1;
      idx  = 4'(ph_idx[m_ph]);
      k    = ph_kind[m_ph];
      if (m_wait || k == 5) begin
        rnd = 4'd11;
        tag = (k == 5) && !m_wait;
      end else begin
        en  = 1'b1;
        rnd = 4'(m_r);
        case (k)
          1: begin sel = (m_r == 0); dn = (m_r == 11) ? 2'd2 : 2'd0; end
          2: begin ack = (m_r == 6); up = (m_r == 6) ? 2'd1 : 2'd0; dn = (m_r == 11) ? 2'd1 : 2'd0; end
          3: begin dsel = 1; ack = (m_r == 6); cv = (m_r == 6); up = (m_r == 6) ? 2'd1 : 2'd0; end
          default: begin
            dsel = 1; ack = (m_r == 0); cv = (m_r == 0);
            up = (m_r == 0) ? 2'd3 : 2'd0; dn = (m_r == 11) ? 2'd2 : 2'd0;
          end
        endcase
      end
    end
    return {ack, dsel, sel, en, rnd, up, dn, cv, tag, busy, idx};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.data_ack_o, bus.data_sel_o, bus.select_o, bus.enable_o, bus.round_o,
            bus.etat_up_o, bus.etat_down_o, bus.cipher_valid_o, bus.tag_valid_o,
            bus.busy_o, bus.block_idx_o};
  endfunction

  function automatic int formula(logic [3:0] nb);
    int n;
    n = (nb == 4'd0) ? 1 : int'(nb);
    return 1 + 12 + 6 + 6 * (n - 1) + 12 + 1;
  endfunction

  // Drive one cycle, sample mid-cycle, then advance the model with the sampled inputs.
  task automatic cycle(input logic st, input logic dv, input logic [3:0] nb,
                       output logic [18:0] o, output logic [18:0] e);
    bus.start_i = st; bus.data_valid_i = dv; bus.nb_blocks_i = nb;
    @(negedge clk);
    o = dut_out();
    e = model_out();
    model_advance(st, dv, nb);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] o;
    rst = 1'b1; bus.start_i = 1'b0; bus.data_valid_i = 1'b0; bus.nb_blocks_i = 4'd0;
    m_idle = 1'b1; m_wait = 1'b0;
    #3;
    o = dut_out();
    checks++;
    if (o !== 19'd0) begin errors++; $display("FAIL reset_state got=%h exp=%h", o, 19'd0); end
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #1;
    o = dut_out();
    checks++;
    if (o !== 19'd0) begin errors++; $display("FAIL reset_release got=%h exp=%h", o, 19'd0); end
  endtask

  task automatic test_single_block(input logic [3:0] nb);
    logic [18:0] o, e;
    int lat = -1;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      cycle(c == 0, 1'b1, nb, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL single_nb%0d c=%0d got=%h exp=%h", nb, c, o, e); end
      if (o[5]) lat = c + 1;
    end
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL single_latency_nb%0d got=%0d exp=32", nb, lat); end
  endtask

  task automatic test_three_blocks();
    logic [18:0] o, e;
    int lat = -1;
    int cvs = 0;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      cycle(c == 0, 1'b1, 4'd3, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL n3 c=%0d got=%h exp=%h", c, o, e); end
      if (o[6]) cvs++;
      if (o[5]) lat = c + 1;
    end
    checks++;
    if (lat !== 44) begin errors++; $display("FAIL n3_latency got=%0d exp=44", lat); end
    checks++;
    if (cvs !== 3) begin errors++; $display("FAIL n3_cipher_count got=%0d exp=3", cvs); end
  endtask

  task automatic test_wait_ad();
    logic [18:0] o, e;
    int lat = -1;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      cycle(c == 0, !(c >= 12 && c <= 16), 4'd1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL wait_ad c=%0d got=%h exp=%h", c, o, e); end
      if (o[5]) lat = c + 1;
    end
    checks++;
    if (lat !== 37) begin errors++; $display("FAIL wait_ad_latency got=%0d exp=37", lat); end
  endtask

  task automatic test_start_during_pt();
    logic [18:0] o, e;
    int lat = -1;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      cycle(c == 0 || c == 21 || c == 22, 1'b1, 4'd4, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL start_in_pt c=%0d got=%h exp=%h", c, o, e); end
      if (o[5]) lat = c + 1;
    end
    checks++;
    if (lat !== 50) begin errors++; $display("FAIL start_in_pt_latency got=%0d exp=50", lat); end
  endtask

  task automatic test_reset_final();
    logic [18:0] o, e;
    int lat = -1;
    for (int c = 0; c < 24; c++) begin
      cycle(c == 0, 1'b1, 4'd1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL abort_run c=%0d got=%h exp=%h", c, o, e); end
    end
    o = dut_out();
    e = model_out();
    checks++;
    if (o !== e || o[14:11] !== 4'd5) begin
      errors++; $display("FAIL abort_final_r5 got=%h exp=%h", o, e);
    end
    bus.start_i = 1'b0;
    #2; rst = 1'b1; #1;
    m_idle = 1'b1; m_wait = 1'b0;
    o = dut_out();
    checks++;
    if (o !== 19'd0) begin errors++; $display("FAIL async_reset got=%h exp=%h", o, 19'd0); end
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      cycle(c == 0, 1'b1, 4'd2, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL restart c=%0d got=%h exp=%h", c, o, e); end
      if (o[5]) lat = c + 1;
    end
    checks++;
    if (lat !== 38) begin errors++; $display("FAIL restart_latency got=%0d exp=38", lat); end
  endtask

  task automatic test_random();
    logic [18:0] o, e;
    logic [3:0] nb, nb_drv;
    int lat, sp, exp_lat;
    for (int run = 0; run < 6; run++) begin
      nb  = 4'($urandom_range(0, 15));
      sp  = int'($urandom_range(1, 80));
      lat = -1;
      for (int c = 0; c < 600 && lat < 0; c++) begin
        nb_drv = (c == 0) ? nb : 4'($urandom_range(0, 15));
        cycle(c == 0 || c == sp, $urandom_range(0, 3) != 0, nb_drv, o, e);
        checks++;
        if (o !== e) begin errors++; $display("FAIL random run%0d c=%0d got=%h exp=%h", run, c, o, e); end
        if (o[5]) lat = c + 1;
      end
      exp_lat = formula(nb) + m_waits;
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL random_latency run%0d nb=%0d got=%0d exp=%0d", run, nb, lat, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block(4'd1);
    test_three_blocks();
    test_wait_ad();
    test_start_during_pt();
    test_reset_final();
    test_single_block(4'd0);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
